interp_pass_sequencer: RTL and testbench

Sequences the 8-tap sub-pixel interpolator over a 16x16 frame, one pass per start. It fetches samples from a frame buffer and applies edge replication at both ends of each line. It streams the samples into the interpolator's data_in and captures the three filter outputs (a/b/c) into a result buffer. A row pass produces a/b/c sub-pixels; a column pass produces d/h/n, or e-i-p / f-j-q / g-k-r when the source buffer holds a, b or c results. Source buffer selection is done outside this block.

---
 rtl/interp_pass_sequencer_if.sv | 30 +++
 rtl/interp_pass_sequencer.sv | 145 ++++++++++++++
 tb/tb_interp_pass_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/interp_pass_sequencer_if.sv
// Handshake/bus bundle between the interpolator pass sequencer and its environment.
// master: controller side (drives start/col_mode, returns frame data and filter outputs).
// slave : the sequencer (drives read address, interpolator feed, result writes, status).
interface interp_pass_sequencer_if;
   logic        start;
   logic        col_mode;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;
   logic [7:0]  data_in;
   logic [31:0] a_value;
   logic [31:0] b_value;
   logic [31:0] c_value;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [13:0] wr_a;
   logic [13:0] wr_b;
   logic [13:0] wr_c;
   logic        busy;
   logic        done;

   modport master (
      output start, col_mode, rd_data, a_value, b_value, c_value,
      input  rd_addr, data_in, wr_en, wr_addr, wr_a, wr_b, wr_c, busy, done
   );

   modport slave (
      input  start, col_mode, rd_data, a_value, b_value, c_value,
      output rd_addr, data_in, wr_en, wr_addr, wr_a, wr_b, wr_c, busy, done
   );
endinterface

// File: rtl/interp_pass_sequencer.sv
// Sequences one 8-tap interpolator pass (row or column) over a 16x16 frame:
// edge-replicated feed from the frame buffer, capture of a/b/c[19:6] into the result buffer.
// Ports: clock, reset (sync, active-high), bus (slave modport: start/col_mode in,
// rd_addr/rd_data frame read, data_in feed, a/b/c_value in, wr_* result write, busy/done).
module interp_pass_sequencer #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
) (
   input logic                    clock,
   input logic                    reset,
   interp_pass_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Per-line step schedule: 31 steps, captures at t=14..29, writes one cycle later.
   localparam logic [4:0] T_LAST = 5'(WIDTH + 14);
   localparam logic [4:0] T_CAP0 = 5'd14;
   localparam logic [4:0] T_CAPN = 5'(WIDTH + 13);
   // Feed position p = clamp(t-7, 0, WIDTH-1); t<=7 replicates element 0,
   // t>=WIDTH+6 replicates the last element (this also holds rd_addr for t=29..30).
   localparam logic [4:0] T_PAD0 = 5'd7;
   localparam logic [4:0] T_PADN = 5'(WIDTH + 6);
   localparam logic [3:0] P_LAST = 4'(WIDTH - 1);
   localparam logic [3:0] I_LAST = 4'(HEIGHT - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  i_q, i_d;
   logic [4:0]  t_q, t_d;
   logic        col_q, col_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [13:0] wr_a_q, wr_a_d;
   logic [13:0] wr_b_q, wr_b_d;
   logic [13:0] wr_c_q, wr_c_d;

   logic [3:0]  feed_pos;
   logic [3:0]  cap_n;
   logic [7:0]  rd_addr;

   always_comb begin
      feed_pos = 4'd0;
      if (t_q >= T_PADN) begin
         feed_pos = P_LAST;
      end else if (t_q > T_PAD0) begin
         feed_pos = 4'(t_q - T_PAD0);
      end
      rd_addr = 8'd0;
      if (state_q == S_RUN) begin
         rd_addr = col_q ? {feed_pos, i_q} : {i_q, feed_pos};
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      t_d       = t_q;
      col_d     = col_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_a_d    = wr_a_q;
      wr_b_d    = wr_b_q;
      wr_c_d    = wr_c_q;
      cap_n     = 4'(t_q - T_CAP0);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               col_d   = bus.col_mode;
               i_d     = 4'd0;
               t_d     = 5'd0;
            end
         end
         S_RUN: begin
            if (t_q == T_LAST) begin
               t_d = 5'd0;
               i_d = i_q + 4'd1;
               if (i_q == I_LAST) begin
                  state_d = S_DONE;
               end
            end else begin
               t_d = t_q + 5'd1;
            end
            // Capture output n at t=n+14; the write appears the following cycle.
            if (t_q >= T_CAP0 && t_q <= T_CAPN) begin
               wr_en_d   = 1'b1;
               wr_addr_d = col_q ? {cap_n, i_q} : {i_q, cap_n};
               wr_a_d    = bus.a_value[19:6];
               wr_b_d    = bus.b_value[19:6];
               wr_c_d    = bus.c_value[19:6];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         i_q       <= 4'd0;
         t_q       <= 5'd0;
         col_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 8'd0;
         wr_a_q    <= 14'd0;
         wr_b_q    <= 14'd0;
         wr_c_q    <= 14'd0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         t_q       <= t_d;
         col_q     <= col_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_a_q    <= wr_a_d;
         wr_b_q    <= wr_b_d;
         wr_c_q    <= wr_c_d;
      end
   end

   // Filter output bits outside [19:6] are intentionally discarded.
   logic unused_filter_bits;
   assign unused_filter_bits = ^{bus.a_value[31:20], bus.a_value[5:0],
                                 bus.b_value[31:20], bus.b_value[5:0],
                                 bus.c_value[31:20], bus.c_value[5:0]};

   assign bus.rd_addr = rd_addr;
   assign bus.data_in = bus.rd_data;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_a    = wr_a_q;
   assign bus.wr_b    = wr_b_q;
   assign bus.wr_c    = wr_c_q;
   assign bus.busy    = (state_q == S_RUN);
   assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_interp_pass_sequencer.sv
module tb_interp_pass_sequencer;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   interp_pass_sequencer_if bus ();

   interp_pass_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mem [256];
   int          wr_cnt [256];
   int          feed_q [$];
   logic [31:0] prev_a, prev_b, prev_c;

   // Frame buffer: one-cycle read latency.
   always @(posedge clock) bus.rd_data <= mem[bus.rd_addr];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", tag, obs, exp, $time);
      end
   endtask

   // Address of source element e of the given line.
   function automatic int elem_addr(input bit col, input int line, input int e);
      return col ? (e * 16 + line) : (line * 16 + e);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_filters();
      prev_a = bus.a_value;
      prev_b = bus.b_value;
      prev_c = bus.c_value;
      bus.a_value = $urandom();
      bus.b_value = $urandom();
      bus.c_value = $urandom();
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_addr", bus.rd_addr, 0);
      check("rst_wr_en",   bus.wr_en,   0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_a",    bus.wr_a,    0);
      check("rst_wr_b",    bus.wr_b,    0);
      check("rst_wr_c",    bus.wr_c,    0);
      check("rst_busy",    bus.busy,    0);
      check("rst_done",    bus.done,    0);
   endtask

   // Called in cycle S; returns in the cycle after the pass (or abort) has settled.
   task automatic run_pass(input bit col, input int abort_at);
      int total;
      int once;
      foreach (wr_cnt[k]) wr_cnt[k] = 0;
      bus.start    = 1'b1;
      bus.col_mode = col;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 496; c++) begin
         int i;
         int t;
         int ta;
         int tp;
         i = c / 31;
         t = c % 31;
         drive_filters();
         bus.col_mode = 1'($urandom_range(0, 1));
         bus.start    = (c == 99);
         if (c == abort_at) reset = 1'b1;
         @(negedge clock);
         check("busy", bus.busy, 1);
         check("done_run", bus.done, 0);
         ta = (t > 28) ? 28 : t;
         check("rd_addr", bus.rd_addr, elem_addr(col, i, feed_q[ta]));
         if (t >= 1) begin
            tp = (t - 1 > 28) ? 28 : t - 1;
            check("data_in", bus.data_in, mem[elem_addr(col, i, feed_q[tp])]);
         end
         check("wr_en", bus.wr_en, (t >= 15));
         if (t >= 15) begin
            check("wr_addr", bus.wr_addr, elem_addr(col, i, t - 15));
            check("wr_a", bus.wr_a, prev_a[19:6]);
            check("wr_b", bus.wr_b, prev_b[19:6]);
            check("wr_c", bus.wr_c, prev_c[19:6]);
         end
         if (bus.wr_en === 1'b1) wr_cnt[bus.wr_addr]++;
         if (c == abort_at) begin
            tick();
            reset     = 1'b0;
            bus.start = 1'b0;
            @(negedge clock);
            check_reset_outputs();
            for (int k = 0; k < 20; k++) begin
               tick();
               @(negedge clock);
               check("abort_done", bus.done, 0);
               check("abort_wr_en", bus.wr_en, 0);
            end
            return;
         end
         tick();
      end
      // Cycle S+497: done pulse; a start here must not be queued.
      bus.start = 1'b1;
      @(negedge clock);
      check("done_pulse", bus.done, 1);
      check("busy_done", bus.busy, 0);
      check("wr_en_done", bus.wr_en, 0);
      tick();
      bus.start = 1'b0;
      @(negedge clock);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      total = 0;
      once  = 0;
      foreach (wr_cnt[k]) begin
         total += wr_cnt[k];
         if (wr_cnt[k] == 1) once++;
      end
      check("write_total", total, 256);
      check("addr_once", once, 256);
   endtask

   initial begin
      // Line feed order: 8 copies of element 0, elements 1..15, 6 copies of element 15.
      for (int k = 0; k < 8; k++) feed_q.push_back(0);
      for (int e = 1; e < 16; e++) feed_q.push_back(e);
      for (int k = 0; k < 6; k++) feed_q.push_back(15);

      for (int k = 0; k < 256; k++) mem[k] = 8'(k);
      reset        = 1'b1;
      bus.start    = 1'b1;
      bus.col_mode = 1'b0;
      bus.a_value  = '0;
      bus.b_value  = '0;
      bus.c_value  = '0;

      // Reset held with start high: reset wins.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      tick();
      reset     = 1'b0;
      bus.start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check("post_rst_wr_en", bus.wr_en, 0);
         check("post_rst_busy", bus.busy, 0);
         tick();
      end

      run_pass(1'b0, -1);                 // row pass, ramp frame
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom());
      run_pass(1'b1, -1);                 // column pass, back-to-back start
      tick();
      run_pass(1'b0, 5 * 31 + 20);        // row pass aborted at line 5, t=20
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom());
      run_pass(1'b1, -1);                 // fresh complete pass after abort
      run_pass(1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
